// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI framing stages.
//   xfer_state_e : per-byte handshake state with the byte engine
//   phase_e      : which part of the command frame is being sent
//   SD_CMD_START : start/transmission bits OR-ed into the command index byte
//   SD_FILL_BYTE : idle MOSI byte (preamble, polling, payload read, trailer)
//   crc7_byte()  : one-byte CRC7 update (x^7 + x^3 + 1), MSB first
package sd_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XFER,
    ST_RELEASE,
    ST_DONE
  } xfer_state_e;

  typedef enum logic [2:0] {
    PH_PRE,
    PH_CMD,
    PH_POLL,
    PH_RESP,
    PH_POST
  } phase_e;

  localparam logic [7:0] SD_CMD_START = 8'h40;
  localparam logic [7:0] SD_FILL_BYTE = 8'hFF;

  // Eight serial CRC steps unrolled into one combinational update.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_spi_crc7.sv
// Registered CRC7 accumulator, one byte per enabled cycle.
//   clk210_p, reset_n_p : clock, asynchronous active-low reset
//   clr                 : restart the CRC at zero (wins over en)
//   en, data            : fold data into the CRC this cycle
//   crc                 : current CRC7 value
module sd_spi_crc7
  import sd_spi_pkg::*;
(
  input  logic       clk210_p,
  input  logic       reset_n_p,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [6:0] crc
);

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p)  crc <= 7'd0;
    else if (clr)    crc <= 7'd0;
    else if (en)     crc <= crc7_byte(crc, data);
  end

endmodule

// File: rtl/sd_spi_cmd_frame.sv
// SD SPI command framing: sends preamble, 6-byte command with CRC7, polls
// for R1, optionally reads a 4-byte R3/R7 payload, then a trailer byte with
// SS released. Drives the byte engine via init_trans / byte_done and owns SS.
//   cmd_*               : request side (start, index, arg, flags) and results
//   sd_spi_ss_n_p       : SD chip select, active-low
//   sd_spi_htransfer_*  : byte to / from the byte engine
//   sd_spi_init_trans_p : transfer request, held until byte_done
//   sd_spi_byte_done_p  : byte complete from the byte engine
module sd_spi_cmd_frame
  import sd_spi_pkg::*;
#(
  parameter int NCR_MAX   = 8,
  parameter int PRE_BYTES = 1
) (
  input  logic        clk210_p,
  input  logic        reset_n_p,
  input  logic        cmd_start_p,
  input  logic [5:0]  cmd_index_p,
  input  logic [31:0] cmd_arg_p,
  input  logic        cmd_long_resp_p,
  input  logic        cmd_keep_ss_p,
  output logic        cmd_busy_p,
  output logic        cmd_done_p,
  output logic [7:0]  cmd_r1_p,
  output logic [31:0] cmd_resp_p,
  output logic        cmd_timeout_p,
  output logic        sd_spi_ss_n_p,
  output logic [7:0]  sd_spi_htransfer_out_p,
  input  logic [7:0]  sd_spi_htransfer_in_p,
  output logic        sd_spi_init_trans_p,
  input  logic        sd_spi_byte_done_p
);

  localparam logic [3:0] PRE_LAST  = 4'(PRE_BYTES - 1);
  localparam logic [7:0] POLL_LAST = 8'(NCR_MAX - 1);
  localparam logic [3:0] CMD_LAST  = 4'd5;
  localparam logic [3:0] RESP_LAST = 4'd3;

  xfer_state_e state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;

  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic        long_q, keep_q;
  logic [7:0]  rx_q;
  logic [6:0]  crc_q;
  logic [7:0]  cur_byte;

  logic accept, frame_end, enter_post, r1_hit, set_timeout, shift_resp;
  logic crc_en;

  assign accept = cmd_start_p && !cmd_busy_p;

  sd_spi_crc7 u_crc (
    .clk210_p (clk210_p),
    .reset_n_p(reset_n_p),
    .clr      (accept),
    .en       (crc_en),
    .data     (cur_byte),
    .crc      (crc_q)
  );

  // State register: handshake state, frame phase and counters.
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_PRE;
      byte_cnt_q <= 4'd0;
      poll_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      byte_cnt_q <= byte_cnt_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  // Next state. Phase decisions happen once per byte, when RELEASE sees
  // byte_done low, using the byte captured in XFER.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    phase_d     = phase_q;
    byte_cnt_d  = byte_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    frame_end   = 1'b0;
    enter_post  = 1'b0;
    r1_hit      = 1'b0;
    set_timeout = 1'b0;
    shift_resp  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d    = ST_LOAD;
          phase_d    = (PRE_BYTES > 0) ? PH_PRE : PH_CMD;
          byte_cnt_d = 4'd0;
          poll_cnt_d = 8'd0;
        end
      end
      ST_LOAD: state_d = ST_XFER;
      ST_XFER: if (sd_spi_byte_done_p) state_d = ST_RELEASE;
      ST_RELEASE: if (!sd_spi_byte_done_p) begin
        state_d    = ST_LOAD;
        byte_cnt_d = byte_cnt_q + 4'd1;
        case (phase_q)
          PH_PRE: if (byte_cnt_q == PRE_LAST) begin
            phase_d    = PH_CMD;
            byte_cnt_d = 4'd0;
          end
          PH_CMD: if (byte_cnt_q == CMD_LAST) begin
            phase_d    = PH_POLL;
            byte_cnt_d = 4'd0;
          end
          PH_POLL: begin
            byte_cnt_d = 4'd0;
            if (!rx_q[7]) begin
              r1_hit = 1'b1;
              if (long_q) phase_d = PH_RESP;
              else        frame_end = 1'b1;
            end else if (poll_cnt_q == POLL_LAST) begin
              set_timeout = 1'b1;
              frame_end   = 1'b1;
            end else begin
              poll_cnt_d = poll_cnt_q + 8'd1;
            end
          end
          PH_RESP: begin
            shift_resp = 1'b1;
            if (byte_cnt_q == RESP_LAST) frame_end = 1'b1;
          end
          default: state_d = ST_DONE;  // PH_POST: trailer sent
        endcase
        if (frame_end) begin
          if (keep_q) begin
            state_d = ST_DONE;
          end else begin
            phase_d    = PH_POST;
            byte_cnt_d = 4'd0;
            enter_post = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state, and the byte to present on LOAD.
  always_comb begin
    cmd_busy_p = (state_q == ST_LOAD) || (state_q == ST_XFER) || (state_q == ST_RELEASE);
    cmd_done_p = (state_q == ST_DONE);
    crc_en     = (state_q == ST_LOAD) && (phase_q == PH_CMD) && (byte_cnt_q < CMD_LAST);
    cur_byte   = SD_FILL_BYTE;
    if (phase_q == PH_CMD) begin
      case (byte_cnt_q)
        4'd0:    cur_byte = SD_CMD_START | {2'b00, idx_q};
        4'd1:    cur_byte = arg_q[31:24];
        4'd2:    cur_byte = arg_q[23:16];
        4'd3:    cur_byte = arg_q[15:8];
        4'd4:    cur_byte = arg_q[7:0];
        default: cur_byte = {crc_q, 1'b1};
      endcase
    end
  end

  // Registered outputs and the captured request.
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      sd_spi_ss_n_p          <= 1'b1;
      sd_spi_init_trans_p    <= 1'b0;
      sd_spi_htransfer_out_p <= SD_FILL_BYTE;
      cmd_r1_p               <= 8'hFF;
      cmd_resp_p             <= 32'd0;
      cmd_timeout_p          <= 1'b0;
      idx_q                  <= 6'd0;
      arg_q                  <= 32'd0;
      long_q                 <= 1'b0;
      keep_q                 <= 1'b0;
      rx_q                   <= 8'd0;
    end else begin
      if (accept) begin
        sd_spi_ss_n_p <= 1'b0;
        idx_q         <= cmd_index_p;
        arg_q         <= cmd_arg_p;
        long_q        <= cmd_long_resp_p;
        keep_q        <= cmd_keep_ss_p;
        cmd_timeout_p <= 1'b0;
        cmd_r1_p      <= 8'hFF;
        cmd_resp_p    <= 32'd0;
      end
      if (state_q == ST_LOAD) begin
        sd_spi_htransfer_out_p <= cur_byte;
        sd_spi_init_trans_p    <= 1'b1;
      end
      if (state_q == ST_XFER && sd_spi_byte_done_p) begin
        sd_spi_init_trans_p <= 1'b0;
        rx_q                <= sd_spi_htransfer_in_p;
      end
      if (r1_hit)     cmd_r1_p <= rx_q;
      if (shift_resp) cmd_resp_p <= {cmd_resp_p[23:0], rx_q};
      if (set_timeout) begin
        cmd_timeout_p <= 1'b1;
        cmd_r1_p      <= 8'hFF;
      end
      if (enter_post) sd_spi_ss_n_p <= 1'b1;
    end
  end

endmodule
